posit_lut_share: RTL
====================

# posit_lut_share

Round-robin arbiter that time-shares one combinational posit LUT function unit (e.g. the 8-bit, ES=1 sigmoid LUT) between `NUM_REQ` requesters. It sits between the requester ports and the single LUT instance. It registers the LUT input and the LUT output in a two-stage pipeline, and routes each result back to the requester that issued it. It sustains one lookup per cycle when no downstream port stalls.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be at least 2.
- `WIDTH`, default 8: posit width, matching the attached LUT.
- `ID_W`, default `$clog2(NUM_REQ)`: requester index width; derived, not overridden.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester grant. A request is accepted when `req_valid[i] && req_ready[i]`.
- `req_data` in `NUM_REQ*WIDTH`: posit operands; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `lut_in` out `WIDTH`: registered operand presented to the LUT.
- `lut_out` in `WIDTH`: LUT result, combinational from `lut_in`.
- `rsp_valid` out `NUM_REQ`: one-hot result valid. At most one bit is high at a time.
- `rsp_ready` in `NUM_REQ`: per-requester result ready.
- `rsp_data` out `WIDTH`: result; meaningful only for the requester whose `rsp_valid` bit is high.
- `busy` out 1: high while stage A or stage B is valid.

## Operation
- Stage A registers: `a_valid`, `a_id`, `a_data`. `lut_in = a_data` at all times.
- Stage B registers: `b_valid`, `b_id`, `b_data`.
- `rsp_valid = b_valid ? (1 << b_id) : 0` and `rsp_data = b_data`.
- Drain condition: `b_free = !b_valid || rsp_ready[b_id]`.
- B load condition: `b_load = a_valid && b_free`. On `b_load`, B takes `{1, a_id, lut_out}`. If `b_free` holds but A is empty, `b_valid` clears.
- A free condition: `a_free = !a_valid || b_free`.
- Arbitration is combinational round-robin with pointer `rr_ptr`. The grant goes to the first `i` with `req_valid[i]`, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- `req_ready[g]` is high only if `a_free` and g is the granted index. Every other `req_ready` bit is 0, and all bits are 0 when `!a_free`.
- On acceptance, A takes `{1, g, req_data[g]}` and `rr_ptr` becomes `(g+1) % NUM_REQ`.
- If `a_free` holds with no acceptance, `a_valid` clears. `rr_ptr` changes only on acceptance.
- `req_ready` depends only on registered state and `req_valid`/`rsp_ready`; it never depends on `req_data`.
- Results return in acceptance order. A requester may have up to two results outstanding (one in A, one in B).
- Backpressure: if `rsp_ready[b_id]` is low, B holds and A holds. No new grant is issued, and all `req_ready` bits are 0. No data is dropped or duplicated.
- Simultaneous drain and refill: B unloading and reloading from A in the same cycle, and A reloading from a new grant in the same cycle, are both legal. Throughput stays at 1 per cycle.
- `rsp_ready` bits for requesters other than `b_id` are ignored.

## Timing
- Reset, asynchronous and active-low: `a_valid=0`, `b_valid=0`, `a_id=0`, `b_id=0`, `a_data=0`, `b_data=0`, `rr_ptr=0`.
- Output values during reset: `lut_in=0`, `rsp_data=0`, `rsp_valid=0`, `busy=0`. `req_ready` follows the grant logic with `a_free=1`.
- Latency: a request accepted at edge k puts its operand on `lut_in` after edge k. Its result is registered at edge k+1, so `rsp_valid` is high from cycle k+1 onward. Accept-to-result is 2 edges with no stall.
- Reset asserted mid-operation clears both stages immediately. In-flight lookups are discarded with no response.
- The LUT path is `a_data` → LUT → `b_data` within one cycle. No other combinational path exists from `req_data` to outputs.

## Test plan
- Single request, sigmoid LUT attached: requester 2 sends `0x00`. `req_ready[2]` is high in the same cycle; `rsp_valid=4'b0100` and `rsp_data=0x30` appear 2 edges later; `rr_ptr` becomes 3.
- All 4 requesters valid continuously, `rsp_ready` all high: grants go 0,1,2,3,0,… One response per cycle, each `rsp_data` matches the LUT model for that requester's operand.
- Backpressure: B holds a result for requester 1 with `rsp_ready[1]=0` for 5 cycles. `rsp_data` stays stable, all `req_ready` are 0 once A is full, and the held lookups complete in order after release.
- Wrap-around: `rr_ptr=3`, `req_valid=4'b1001`. Grant goes to 3, then 0.
- Reset mid-flight: `resetn` drops with A and B both valid. `rsp_valid=0` and `busy=0` immediately, and the first grant after release starts from index 0.
- Back-to-back same requester: requester 0 issues `0x00`, `0x40`, `0x80` on consecutive cycles with no contention. Results arrive in order on consecutive cycles and match the LUT model.

Source files
------------

// File: rtl/posit_lut_share.sv
// rtl/posit_lut_share.sv - round-robin sharing of one combinational posit LUT between requesters
//
// Ports:
//   clock      in  1              rising-edge clock
//   resetn     in  1              asynchronous active-low reset
//   req_valid  in  NUM_REQ        per-requester operand valid
//   req_ready  out NUM_REQ        per-requester grant (at most one bit high)
//   req_data   in  NUM_REQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   lut_in     out WIDTH          registered operand driven into the shared LUT
//   lut_out    in  WIDTH          LUT result, combinational from lut_in
//   rsp_valid  out NUM_REQ        one-hot result valid
//   rsp_ready  in  NUM_REQ        per-requester result ready
//   rsp_data   out WIDTH          result for the requester flagged in rsp_valid
//   busy       out 1              either pipeline stage holds a lookup

module posit_lut_share #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [WIDTH-1:0]         lut_in,
  input  logic [WIDTH-1:0]         lut_out,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Stage A: operand presented to the LUT
  logic             a_valid_q, a_valid_d;
  logic [ID_W-1:0]  a_id_q, a_id_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;

  // Stage B: LUT result waiting for its requester
  logic             b_valid_q, b_valid_d;
  logic [ID_W-1:0]  b_id_q, b_id_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic             b_free;
  logic             a_free;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             accept;
  int               cand;

  // Only the requester owning stage B can stall the pipe; other rsp_ready bits are don't-care.
  assign b_free = !b_valid_q || rsp_ready[b_id_q];
  assign a_free = !a_valid_q || b_free;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Operand mux is kept apart from the grant so req_ready never depends on req_data.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept    = a_free && grant_found;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    a_valid_d = a_valid_q;
    a_id_d    = a_id_q;
    a_data_d  = a_data_q;
    b_valid_d = b_valid_q;
    b_id_d    = b_id_q;
    b_data_d  = b_data_q;
    rr_ptr_d  = rr_ptr_q;

    // B drains and refills from A in the same cycle when possible.
    if (b_free) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_id_d   = a_id_q;
        b_data_d = lut_out;
      end
    end

    if (a_free) begin
      a_valid_d = accept;
      if (accept) begin
        a_id_d   = grant_idx;
        a_data_d = grant_data;
        rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_valid_q <= 1'b0;
      a_id_q    <= '0;
      a_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_id_q    <= '0;
      b_data_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_id_q    <= a_id_d;
      a_data_q  <= a_data_d;
      b_valid_q <= b_valid_d;
      b_id_q    <= b_id_d;
      b_data_q  <= b_data_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign lut_in    = a_data_q;
  assign rsp_data  = b_data_q;
  assign rsp_valid = b_valid_q ? (NUM_REQ'(1) << b_id_q) : '0;
  assign busy      = a_valid_q || b_valid_q;

endmodule
